// File: rtl/mult_drain.sv
// ---------------------------------------------------------------------------
// mult_drain
//
// Result drain buffer sitting behind a floating-point multiplier pipeline.
// Arriving products (with their status flags and sequence tag) are queued in
// a small strict-FIFO buffer and presented downstream with a valid/ready
// handshake. The pipeline is held off with an active-low accept that is
// decoded purely from the registered occupancy count, so there is no
// combinational path from out_ready or arrive back to accept_n.
//
// The block also checks that tags arrive in sequence (sticky seq_err) and
// accumulates a sticky OR of every accepted status word.
//
// Ports
//   clk         rising-edge clock, all state
//   rst_n       asynchronous active-low reset
//   arrive      pipeline output valid
//   arrive_id   tag of the arriving result            [ID_W]
//   z           arriving product                      [DATA_W]
//   status      arriving IEEE status flags            [8]
//   accept_n    1 = pipeline must hold its output (buffer full)
//   out_valid   head entry available downstream
//   out_ready   downstream accepts the head entry
//   out_data    head product                          [DATA_W]
//   out_status  head status flags                     [8]
//   out_id      head tag                              [ID_W]
//   count       entries currently held                [$clog2(DEPTH)+1]
//   seq_err     sticky tag-order error
//   status_or   sticky OR of all accepted status words [8]
// ---------------------------------------------------------------------------
module mult_drain #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 3,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       arrive,
    input  logic [ID_W-1:0]            arrive_id,
    input  logic [DATA_W-1:0]          z,
    input  logic [7:0]                 status,
    output logic                       accept_n,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [7:0]                 out_status,
    output logic [ID_W-1:0]            out_id,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       seq_err,
    output logic [7:0]                 status_or
);

    localparam int PW      = $clog2(DEPTH);
    localparam int CW      = PW + 1;
    localparam int ENTRY_W = 8 + ID_W + DATA_W;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Registered state
    logic [PW-1:0]   wr_ptr_reg,    wr_ptr_next;
    logic [PW-1:0]   rd_ptr_reg,    rd_ptr_next;
    logic [CW-1:0]   count_reg,     count_next;
    logic [ID_W-1:0] exp_id_reg,    exp_id_next;
    logic            seq_err_reg,   seq_err_next;
    logic [7:0]      status_or_reg, status_or_next;

    // Buffer storage; contents are never reset, only the pointers/count are.
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] head;
    logic [DEPTH-1:0]   wr_en;

    // Full/empty come from the registered count only.
    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);

    // When full, accept_n is high so no push can happen even if a pop frees
    // a slot this cycle; the new slot becomes visible on the next cycle.
    assign push = arrive & ~full;
    assign pop  = ~empty & out_ready;

    assign entry_in = {status, arrive_id, z};

    // One write enable per entry, decoded from the write pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem[i] <= entry_in;
            end
        end
    end

    // Head entry is read combinationally so data is valid together with
    // out_valid on the cycle after a push into an empty buffer.
    assign head = mem[rd_ptr_reg];

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        exp_id_next    = exp_id_reg;
        seq_err_next   = seq_err_reg;
        status_or_next = status_or_reg;

        if (push) begin
            wr_ptr_next    = wr_ptr_reg + PW'(1);
            status_or_next = status_or_reg | status;
            // Resynchronise to the observed tag so one gap reports once.
            exp_id_next    = arrive_id + ID_W'(1);
            if (arrive_id != exp_id_reg) begin
                seq_err_next = 1'b1;
            end
        end

        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            exp_id_reg    <= '0;
            seq_err_reg   <= 1'b0;
            status_or_reg <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            exp_id_reg    <= exp_id_next;
            seq_err_reg   <= seq_err_next;
            status_or_reg <= status_or_next;
        end
    end

    assign accept_n   = full;
    assign out_valid  = ~empty;
    assign out_data   = head[DATA_W-1:0];
    assign out_id     = head[DATA_W +: ID_W];
    assign out_status = head[ENTRY_W-1 -: 8];
    assign count      = count_reg;
    assign seq_err    = seq_err_reg;
    assign status_or  = status_or_reg;

endmodule

// File: tb/tb_mult_drain.sv
// ---------------------------------------------------------------------------
// tb_mult_drain
//
// Directed testbench for mult_drain (DATA_W=32, ID_W=3, DEPTH=4). Inputs are
// driven 1 ns after the rising edge and outputs are sampled there (or 1 ns
// later for combinational head outputs). Ends with a random-ready run checked
// against a small queue model.
// ---------------------------------------------------------------------------
module tb_mult_drain;

    logic        clk;
    logic        rst_n;
    logic        arrive;
    logic [2:0]  arrive_id;
    logic [31:0] z;
    logic [7:0]  status;
    logic        accept_n;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_status;
    logic [2:0]  out_id;
    logic [2:0]  count;
    logic        seq_err;
    logic [7:0]  status_or;

    int tests = 0;
    int fails = 0;

    mult_drain #(
        .DATA_W(32),
        .ID_W  (3),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arrive    (arrive),
        .arrive_id (arrive_id),
        .z         (z),
        .status    (status),
        .accept_n  (accept_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_status(out_status),
        .out_id    (out_id),
        .count     (count),
        .seq_err   (seq_err),
        .status_or (status_or)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse issued between edges; effect checked before
    // any clock edge arrives.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rst_count", count, 0);
        check("rst_valid", out_valid, 0);
        check("rst_accept_n", accept_n, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_status_or", status_or, 0);
        tick();
        rst_n = 1'b1;
    endtask

    logic [2:0]  ids_seq [4];
    logic        err_seq [4];
    logic [31:0] sb_data [$];
    logic [2:0]  sb_id   [$];
    int          pushed;
    int          mcount;
    int          cyc;
    logic [7:0]  mor;
    logic        do_push;
    logic        do_pop;

    initial begin
        rst_n     = 1'b0;
        arrive    = 1'b0;
        arrive_id = '0;
        z         = '0;
        status    = '0;
        out_ready = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) tick();
        check("reset_count", count, 0);
        check("reset_valid", out_valid, 0);
        check("reset_accept_n", accept_n, 0);
        check("reset_seq_err", seq_err, 0);
        check("reset_status_or", status_or, 0);
        rst_n = 1'b1;

        // ---------------- single push, 1-cycle latency, immediate drain ----
        arrive    = 1'b1;
        arrive_id = 3'd0;
        z         = 32'h3F80_0000;
        status    = 8'h00;
        out_ready = 1'b1;
        tick();
        arrive = 1'b0;
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 32'h3F80_0000);
        check("t1_id", out_id, 0);
        check("t1_count", count, 1);
        tick();
        check("t1_count_after_pop", count, 0);
        check("t1_valid_after_pop", out_valid, 0);

        // ---------------- fill to full, hold, drain ----------------
        out_ready = 1'b0;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            arrive    = 1'b1;
            arrive_id = 3'(i);
            z         = 32'hA0 + 32'(i);
            tick();
            check("fill_count", count, 64'(i + 1));
            check("fill_accept_n", accept_n, (i == 3));
        end
        // Pipeline holds id 4 while the buffer is full; nothing may change.
        arrive_id = 3'd4;
        z         = 32'hA4;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("full_count", count, 4);
            check("full_accept_n", accept_n, 1);
            check("full_head_id", out_id, 0);
            check("full_head_data", out_data, 32'hA0);
        end
        // Full + ready + arrive: pop only.
        out_ready = 1'b1;
        #1;
        check("full_pop_valid", out_valid, 1);
        tick();
        check("full_pop_count", count, 3);
        check("full_pop_accept_n", accept_n, 0);
        check("full_pop_head", out_id, 1);
        // id 4 now accepted while id 1 pops
        tick();
        check("pp4_count", count, 3);
        check("pp4_head", out_id, 2);
        arrive_id = 3'd5;
        z         = 32'hA5;
        tick();
        check("pp5_count", count, 3);
        check("pp5_head", out_id, 3);
        check("pp5_data", out_data, 32'hA3);
        arrive = 1'b0;
        tick();
        check("drain_head4_id", out_id, 4);
        check("drain_head4_data", out_data, 32'hA4);
        check("drain_count2", count, 2);
        tick();
        check("drain_head5_id", out_id, 5);
        check("drain_head5_data", out_data, 32'hA5);
        check("drain_count1", count, 1);
        tick();
        check("drain_count0", count, 0);
        check("drain_valid0", out_valid, 0);
        check("drain_seq_err", seq_err, 0);
        // Ready with empty buffer has no effect.
        tick();
        check("empty_ready_count", count, 0);

        // ---------------- tag sequence error ----------------
        pulse_reset();
        ids_seq = '{3'd0, 3'd1, 3'd3, 3'd4};
        err_seq = '{1'b0, 1'b0, 1'b1, 1'b1};
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            arrive    = 1'b1;
            arrive_id = ids_seq[k];
            z         = 32'h100 + 32'(k);
            tick();
            check("seq_err", seq_err, err_seq[k]);
            check("seq_head_id", out_id, ids_seq[k]);
            check("seq_count", count, 1);
        end
        arrive = 1'b0;
        tick();
        check("seq_err_sticky", seq_err, 1);
        check("seq_drained", count, 0);

        // ---------------- status OR and async reset mid-operation ----------
        pulse_reset();
        out_ready = 1'b0;
        arrive    = 1'b1;
        arrive_id = 3'd0;
        z         = 32'h200;
        status    = 8'h01;
        tick();
        arrive_id = 3'd1;
        z         = 32'h201;
        status    = 8'h10;
        tick();
        arrive = 1'b0;
        status = 8'h00;
        check("sor_value", status_or, 8'h11);
        check("sor_count", count, 2);
        check("sor_head_status", out_status, 8'h01);
        pulse_reset();

        // ---------------- random ready, wrap, scoreboard ----------------
        pushed = 0;
        mcount = 0;
        cyc    = 0;
        mor    = '0;
        while ((pushed < 11 || mcount != 0) && cyc < 200) begin
            arrive    = (pushed < 11);
            arrive_id = 3'(pushed);
            z         = $urandom;
            status    = 8'(1 << (pushed % 8));
            out_ready = 1'($urandom_range(0, 1));
            #1;
            check("rnd_accept_n", accept_n, (mcount == 4));
            check("rnd_valid", out_valid, (mcount != 0));
            do_push = arrive && (mcount != 4);
            do_pop  = out_ready && (mcount != 0);
            if (do_pop) begin
                check("rnd_data", out_data, sb_data[0]);
                check("rnd_id", out_id, sb_id[0]);
                void'(sb_data.pop_front());
                void'(sb_id.pop_front());
            end
            if (do_push) begin
                sb_data.push_back(z);
                sb_id.push_back(arrive_id);
                mor = mor | status;
                pushed++;
            end
            mcount = mcount + int'(do_push) - int'(do_pop);
            tick();
            cyc++;
            check("rnd_count", count, 64'(mcount));
        end
        arrive    = 1'b0;
        out_ready = 1'b0;
        check("rnd_completed", (pushed == 11 && mcount == 0), 1);
        check("rnd_seq_err", seq_err, 0);
        check("rnd_status_or", status_or, mor);
        check("rnd_final_count", count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_drain.md
MULT_DRAIN -- requirements
Module: mult_drain

Interface
REQ-001 Parameter: DATA_W, default 32, width of the result word z.
REQ-002 Parameter: ID_W, default 3, width of the arrive_id tag.
REQ-003 Parameter: DEPTH, default 4, result buffer entries; power of 2, >= 2.
REQ-004 Port: clk  input  1  single clock; all state on its rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: arrive  input  1  pipeline output valid.
REQ-007 Port: arrive_id  input  ID_W  tag of the arriving result.
REQ-008 Port: z  input  DATA_W  arriving product.
REQ-009 Port: status  input  8  arriving IEEE status flags.
REQ-010 Port: accept_n  output  1  active-low accept to the pipeline; 1 = pipeline holds its output.
REQ-011 Port: out_valid  output  1  head entry available downstream.
REQ-012 Port: out_ready  input  1  downstream accepts head entry.
REQ-013 Port: out_data  output  DATA_W  head product.
REQ-014 Port: out_status  output  8  head status.
REQ-015 Port: out_id  output  ID_W  head tag.
REQ-016 Port: count  output  $clog2(DEPTH)+1  entries held.
REQ-017 Port: seq_err  output  1  sticky tag-order error.
REQ-018 Port: status_or  output  8  sticky bitwise OR of all accepted status words.

Function
REQ-019 Push = arrive & ~accept_n; pop = out_valid & out_ready; each moves exactly one entry per cycle.
REQ-020 accept_n SHALL be 1 exactly when count == DEPTH, decoded from registered count only; no combinational path from out_ready or arrive.
REQ-021 Full and pop in the same cycle: pop completes, no push; accept_n falls the next cycle.
REQ-022 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, order preserved.
REQ-023 Push into empty buffer: out_valid = 1 on the next cycle, out_data/out_status/out_id = pushed values (1-cycle latency).
REQ-024 out_valid = (count != 0); out_data/out_status/out_id are read combinationally from the head entry and stable while out_valid & ~out_ready.
REQ-025 Buffer is strict FIFO; read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-026 count SHALL never exceed DEPTH nor underflow; out_ready with count == 0 has no effect.
REQ-027 Expected-tag register exp_id starts at 0 and increments modulo 2^ID_W on each push.
REQ-028 A push with arrive_id != exp_id SHALL set seq_err the next cycle; the entry is still stored, and exp_id becomes arrive_id + 1 modulo 2^ID_W.
REQ-029 seq_err and status_or are cleared only by reset; status_or |= status on each push.
REQ-030 arrive with accept_n = 1 SHALL not alter any state.

Reset
REQ-031 While rst_n = 0: accept_n = 0, out_valid = 0, count = 0, seq_err = 0, status_or = 0, exp_id = 0, pointers = 0.
REQ-032 Reset asserted mid-operation discards all buffered entries immediately; buffer data contents need not be cleared.
REQ-033 After rst_n rises, the first push is accepted on the first clock edge.

Verification
REQ-034 Push z=0x3F800000, status=0x00, id=0 into empty buffer, out_ready=1 -> out_valid=1 next cycle with out_data=0x3F800000 and out_id=0; count returns to 0 one cycle later.
REQ-035 out_ready=0, arrive=1 for 6 cycles with ids 0..5 -> ids 0..3 stored, accept_n=1 from the cycle after the 4th push, count=4; drain with out_ready=1 -> outputs in order 0,1,2,3 and ids 4,5 are accepted after accept_n falls.
REQ-036 Full buffer, out_ready=1 and arrive=1 together -> one pop, no push, count=3, accept_n=0 next cycle.
REQ-037 Push ids 0,1,3 -> seq_err=1 the cycle after id 3; the next push with id 4 raises no further error and seq_err stays 1 until reset.
REQ-038 Push status 0x01 then 0x10 -> status_or=0x11; rst_n pulse with count=2 -> count=0, out_valid=0, status_or=0 asynchronously.
REQ-039 Run 2^ID_W+3 sequential pushes with random out_ready -> no seq_err, data order matches a scoreboard, and the pointers and exp_id wrap correctly.
